// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - data-bus bridge: memory-stage request to registered req/ack bus transaction
// Optional bus timeout with error pulse enabled by DBUS_TIMEOUT_EN.
module dbus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_o,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_i,
  output logic        stall,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_o,
  output logic [3:0]  bus_byte_en,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   req;

  assign req = mem_rd | mem_wr;

  // DONE releases the pipeline for one cycle even though the request is still held
  assign stall = ~rst & ((state == BUSY) | ((state == IDLE) & req));

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_data_i  <= 32'd0;
      bus_address <= 32'd0;
      bus_data_o  <= 32'd0;
      bus_byte_en <= 4'd0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      bus_err     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            bus_address <= mem_address;
            bus_data_o  <= mem_data_o;
            bus_byte_en <= mem_byte_en;
            bus_write   <= mem_wr;
            bus_read    <= mem_rd & ~mem_wr;
            state       <= BUSY;
`ifdef DBUS_TIMEOUT_EN
            cnt         <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_ack) begin
            if (bus_read) mem_data_i <= bus_data_i;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          // cnt counts completed BUSY cycles; this is the last one allowed
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (bus_read) mem_data_i <= 32'hFFFF_FFFF;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_err   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef DBUS_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - self-checking bench for dbus_bridge with a transaction-level reference model
module tb_dbus_bridge;

`ifdef DBUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address, mem_data_o, bus_data_i;
  logic        mem_rd, mem_wr, bus_ack;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_i, bus_address, bus_data_o;
  logic [3:0]  bus_byte_en;
  logic        stall, bus_read, bus_write, bus_err;

  int checks = 0;
  int errors = 0;

  dbus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_data_o(mem_data_o),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte_en(mem_byte_en),
    .mem_data_i(mem_data_i), .stall(stall),
    .bus_address(bus_address), .bus_data_o(bus_data_o), .bus_byte_en(bus_byte_en),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_i(bus_data_i), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request, one release cycle after completion
  bit          mchk = 0;
  bit          m_busy = 0, m_done = 0, m_err = 0, m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_be = 0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mchk = 1; m_busy = 0; m_done = 0; m_err = 0; m_wr = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0; m_cnt = 0;
    end else begin
      m_err = 0;
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (bus_ack) begin
          if (!m_wr) m_rdata = bus_data_i;
          m_busy = 0; m_done = 1;
        end else begin
          m_cnt++;
`ifdef DBUS_TIMEOUT_EN
          if (m_cnt == TO) begin
            if (!m_wr) m_rdata = 32'hFFFF_FFFF;
            m_busy = 0; m_done = 1; m_err = 1;
          end
`endif
        end
      end else if (mem_rd || mem_wr) begin
        m_addr = mem_address; m_wdata = mem_data_o; m_be = mem_byte_en;
        m_wr = mem_wr; m_busy = 1; m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      chk("stall", 32'(stall), 32'(rst ? 1'b0 : m_busy ? 1'b1 : m_done ? 1'b0 : (mem_rd | mem_wr)));
      chk("bus_read", 32'(bus_read), 32'(m_busy & ~m_wr));
      chk("bus_write", 32'(bus_write), 32'(m_busy & m_wr));
      chk("bus_address", bus_address, m_addr);
      chk("bus_data_o", bus_data_o, m_wdata);
      chk("bus_byte_en", 32'(bus_byte_en), 32'(m_be));
      chk("mem_data_i", mem_data_i, m_rdata);
      chk("bus_err", 32'(bus_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, ack after 'waits' extra BUSY cycles, observe the DONE cycle
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int waits, input logic [31:0] rdat,
                     input bit drop_after, input logic [31:0] exp_mdi,
                     output int nstall, output int nstrobe);
    nstall = 0; nstrobe = 0;
    mem_rd = rd; mem_wr = wr; mem_address = a; mem_data_o = d; mem_byte_en = be;
    @(negedge clk);
    if (stall) nstall++;
    tick();
    for (int i = 0; i <= waits; i++) begin
      bus_ack = (i == waits);
      bus_data_i = (i == waits) ? rdat : $urandom;
      mem_address = $urandom; mem_data_o = $urandom; mem_byte_en = 4'($urandom);
      @(negedge clk);
      if (stall) nstall++;
      if (bus_read | bus_write) nstrobe++;
      chk("txn_addr", bus_address, a);
      chk("txn_wdata", bus_data_o, d);
      chk("txn_be", 32'(bus_byte_en), 32'(be));
      chk("txn_write", 32'(bus_write), 32'(wr));
      chk("txn_read", 32'(bus_read), 32'(rd & ~wr));
      tick();
    end
    bus_ack = 1'b0;
    if (drop_after) begin mem_rd = 1'b0; mem_wr = 1'b0; end
    else begin mem_address = a; mem_data_o = d; mem_byte_en = be; end
    @(negedge clk);
    if (stall) nstall++;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_strobes", 32'(bus_read | bus_write), 32'd0);
    chk("done_mem_data_i", mem_data_i, exp_mdi);
    chk("done_bus_err", 32'(bus_err), 32'd0);
    tick();
  endtask

  int ns, nb;

  initial begin
    rst = 1; mem_rd = 0; mem_wr = 0; mem_address = 0; mem_data_o = 0; mem_byte_en = 0;
    bus_ack = 0; bus_data_i = 0;
    tick();
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_data_i", mem_data_i, 32'd0);
    chk("reset_strobes", 32'(bus_read | bus_write | bus_err), 32'd0);
    tick();
    rst = 0;

    txn(1, 0, 32'h8000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, ns, nb);
    chk("read0_stall_cycles", 32'(ns), 32'd2);
    chk("read0_strobe_cycles", 32'(nb), 32'd1);

    txn(0, 1, 32'h0000_0400, 32'h1234_1234, 4'b0011, 3, 32'h0, 1, 32'hDEAD_BEEF, ns, nb);
    chk("write3_stall_cycles", 32'(ns), 32'd5);
    chk("write3_strobe_cycles", 32'(nb), 32'd4);

    txn(1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, ns, nb);
    chk("b2b_first_stall", 32'(ns), 32'd2);
    txn(1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h0BAD_C0DE, 1, 32'h0BAD_C0DE, ns, nb);
    chk("b2b_second_stall", 32'(ns), 32'd2);
    chk("b2b_second_strobe", 32'(nb), 32'd1);

    txn(1, 1, 32'h0000_0080, 32'hA5A5_5A5A, 4'b1100, 1, 32'h7777_7777, 1, 32'h0BAD_C0DE, ns, nb);
    chk("conflict_strobe_cycles", 32'(nb), 32'd2);

    bus_ack = 1; bus_data_i = 32'h5555_5555;
    @(negedge clk);
    chk("stray_ack_stall", 32'(stall), 32'd0);
    tick();
    bus_ack = 0;
    @(negedge clk);
    chk("stray_ack_mem_data_i", mem_data_i, 32'h0BAD_C0DE);
    chk("stray_ack_strobes", 32'(bus_read | bus_write), 32'd0);
    tick();

    mem_rd = 1; mem_address = 32'h0000_0100;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; mem_rd = 0;
    @(negedge clk);
    chk("midreset_strobes", 32'(bus_read | bus_write), 32'd0);
    chk("midreset_address", bus_address, 32'd0);
    chk("midreset_mem_data_i", mem_data_i, 32'd0);
    chk("midreset_stall", 32'(stall), 32'd0);
    tick();
    bus_ack = 1; bus_data_i = 32'h1111_2222;
    tick();
    bus_ack = 0;
    @(negedge clk);
    chk("late_ack_mem_data_i", mem_data_i, 32'd0);
    tick();

`ifdef DBUS_TIMEOUT_EN
    mem_rd = 1; mem_address = 32'h0000_0200;
    tick();
    mem_rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_busy_read", 32'(bus_read), 32'd1);
      chk("to_busy_err", 32'(bus_err), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_mem_data_i", mem_data_i, 32'hFFFF_FFFF);
    chk("to_strobe", 32'(bus_read), 32'd0);
    tick();
    @(negedge clk);
    chk("to_err_clear", 32'(bus_err), 32'd0);
    tick();
    txn(1, 0, 32'h0000_0204, 32'h0, 4'hF, 7, 32'h600D_F00D, 1, 32'h600D_F00D, ns, nb);
    chk("to_ack8_stall", 32'(ns), 32'd9);
`endif

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_rd = ($urandom_range(0, 2) == 0);
      mem_wr = ($urandom_range(0, 3) == 0);
      mem_address = $urandom; mem_data_o = $urandom; mem_byte_en = 4'($urandom);
      bus_ack = ($urandom_range(0, 2) == 0);
      bus_data_i = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
